// File: rtl/bailey_border_ctrl.sv
// Control unit for the 7x7 window/row-buffer block: accepts the raster stream, flushes with
// zero pushes, tracks the window centre and drives mirror-without-duplication border selects.
module bailey_border_ctrl #(
  parameter int unsigned ROW_WIDTH  = 100,
  parameter int unsigned NUM_ROWS   = 100,
  parameter int unsigned PIX_BIT    = 8,
  parameter int unsigned MASK_WIDTH = 7,
  parameter int unsigned MASK_LAT   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PIX_BIT-1:0] pix_in,
  input  logic               pix_in_valid,
  output logic               pix_in_ready,
  output logic               ctrl2buf_valid,
  output logic [PIX_BIT-1:0] data_cu2bufcf,
  output logic               sel_top_row,
  output logic [1:0]         sel_btm_row,
  output logic               sel_left_col,
  output logic [1:0]         sel_right_col,
  output logic               win_valid,
  output logic               frame_done
);

  localparam int unsigned Radius   = MASK_WIDTH / 2;
  localparam int unsigned NumPix   = ROW_WIDTH * NUM_ROWS;
  localparam int unsigned NumFlush = Radius * ROW_WIDTH + Radius;
  localparam int unsigned PixW     = $clog2(NumPix);
  localparam int unsigned FlushW   = $clog2(NumFlush);
  localparam int unsigned ColW     = $clog2(ROW_WIDTH);
  localparam int unsigned RowW     = $clog2(NUM_ROWS);
  localparam int unsigned BtmTh    = NUM_ROWS - 1 - Radius;
  localparam int unsigned RgtTh    = ROW_WIDTH - 1 - Radius;

  typedef enum logic [1:0] {StIdle, StStream, StFlush, StDone} state_e;

  state_e              state_q;
  logic [PixW-1:0]     pix_cnt_q;
  logic [FlushW-1:0]   flush_cnt_q;
  logic [FlushW-1:0]   fill_cnt_q;
  logic                fill_done_q;
  logic [RowW-1:0]     rc_q;
  logic [ColW-1:0]     cc_q;
  // Bit 0 travels with the push; bit MASK_LAT lines up with the mask output.
  logic [MASK_LAT:0]   wv_q;
  logic                push;

  assign push         = ((state_q == StStream) && pix_in_valid) || (state_q == StFlush);
  assign pix_in_ready = (state_q == StStream);
  assign win_valid    = wv_q[MASK_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      pix_cnt_q      <= '0;
      flush_cnt_q    <= '0;
      fill_cnt_q     <= '0;
      fill_done_q    <= 1'b0;
      rc_q           <= '0;
      cc_q           <= '0;
      wv_q           <= '0;
      ctrl2buf_valid <= 1'b0;
      data_cu2bufcf  <= '0;
      sel_top_row    <= 1'b0;
      sel_btm_row    <= 2'd0;
      sel_left_col   <= 1'b0;
      sel_right_col  <= 2'd0;
      frame_done     <= 1'b0;
    end else begin
      ctrl2buf_valid <= 1'b0;
      frame_done     <= 1'b0;
      wv_q           <= {wv_q[MASK_LAT-1:0], push && fill_done_q};

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StStream;
            pix_cnt_q   <= '0;
            flush_cnt_q <= '0;
            fill_cnt_q  <= '0;
            fill_done_q <= 1'b0;
            rc_q        <= '0;
            cc_q        <= '0;
          end
        end
        StStream: begin
          if (pix_in_valid) begin
            if (pix_cnt_q == PixW'(NumPix - 1)) begin
              state_q   <= StFlush;
              pix_cnt_q <= '0;
            end else begin
              pix_cnt_q <= pix_cnt_q + 1'b1;
            end
          end
        end
        StFlush: begin
          if (flush_cnt_q == FlushW'(NumFlush - 1)) begin
            state_q     <= StDone;
            flush_cnt_q <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        StDone: begin
          frame_done <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (push) begin
        ctrl2buf_valid <= 1'b1;
        data_cu2bufcf  <= (state_q == StStream) ? pix_in : '0;
        if (fill_done_q) begin
          sel_top_row   <= (rc_q < RowW'(Radius));
          sel_btm_row   <= (rc_q > RowW'(BtmTh)) ? 2'(rc_q - RowW'(BtmTh)) : 2'd0;
          sel_left_col  <= (cc_q < ColW'(Radius));
          sel_right_col <= (cc_q > ColW'(RgtTh)) ? 2'(cc_q - ColW'(RgtTh)) : 2'd0;
          if (cc_q == ColW'(ROW_WIDTH - 1)) begin
            cc_q <= '0;
            rc_q <= (rc_q == RowW'(NUM_ROWS - 1)) ? '0 : rc_q + 1'b1;
          end else begin
            cc_q <= cc_q + 1'b1;
          end
        end else begin
          // Fill phase: no centre exists yet, so borders stay deselected.
          sel_top_row   <= 1'b0;
          sel_btm_row   <= 2'd0;
          sel_left_col  <= 1'b0;
          sel_right_col <= 2'd0;
          if (fill_cnt_q == FlushW'(NumFlush - 1)) begin
            fill_done_q <= 1'b1;
          end
          fill_cnt_q <= fill_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bailey_border_ctrl.sv
// Directed bench for bailey_border_ctrl at W=H=8: push/selector/win_valid sequences, flush,
// stalls, mid-frame reset and ignored start pulses.
module tb_bailey_border_ctrl;
  localparam int W     = 8;
  localparam int H     = 8;
  localparam int P     = 27;
  localparam int NPIX  = 64;
  localparam int NPUSH = 91;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pix_in = 8'd0;
  logic       pix_in_valid = 1'b0;
  logic       pix_in_ready, ctrl2buf_valid, sel_top_row, sel_left_col, win_valid, frame_done;
  logic [7:0] data_cu2bufcf;
  logic [1:0] sel_btm_row, sel_right_col;

  bailey_border_ctrl #(
    .ROW_WIDTH(W), .NUM_ROWS(H), .PIX_BIT(8), .MASK_WIDTH(7), .MASK_LAT(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pix_in(pix_in), .pix_in_valid(pix_in_valid),
    .pix_in_ready(pix_in_ready), .ctrl2buf_valid(ctrl2buf_valid),
    .data_cu2bufcf(data_cu2bufcf), .sel_top_row(sel_top_row), .sel_btm_row(sel_btm_row),
    .sel_left_col(sel_left_col), .sel_right_col(sel_right_col), .win_valid(win_valid),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int          cyc = 0, np = 0, nwv = 0, nfd = 0;
  logic [13:0] push_rec [1024];
  int          push_cyc [1024];
  int          wv_cyc   [1024];
  int          fd_cyc   [16];
  int          n_err = 0, n_chk = 0;

  always @(negedge clk) begin
    cyc++;
    if (ctrl2buf_valid && np < 1024) begin
      push_rec[np] = {data_cu2bufcf, sel_top_row, sel_btm_row, sel_left_col, sel_right_col};
      push_cyc[np] = cyc;
      np++;
    end
    if (win_valid && nwv < 1024) begin
      wv_cyc[nwv] = cyc;
      nwv++;
    end
    if (frame_done && nfd < 16) begin
      fd_cyc[nfd] = cyc;
      nfd++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix_val(input int i);
    return 8'(i * 5 + 3);
  endfunction

  // Reference: centre from push index by division, independent of any counters.
  function automatic logic [13:0] exp_push(input int n);
    int k, rc, cc;
    logic [7:0] d;
    logic top, left;
    logic [1:0] btm, rgt;
    d = (n < NPIX) ? pix_val(n) : 8'd0;
    top = 1'b0; left = 1'b0; btm = 2'd0; rgt = 2'd0;
    if (n >= P) begin
      k = n - P; rc = k / W; cc = k % W;
      top  = (rc < 3);
      left = (cc < 3);
      btm  = (rc > H - 4) ? 2'(rc - (H - 4)) : 2'd0;
      rgt  = (cc > W - 4) ? 2'(cc - (W - 4)) : 2'd0;
    end
    return {d, top, btm, left, rgt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input bit toggle, input int npix, input int start_at);
    for (int i = 0; i < npix; i++) begin
      pix_in_valid = 1'b1;
      pix_in = pix_val(i);
      start = (i == start_at);
      if (!pix_in_ready) begin
        chk($sformatf("ready_in_stream pix%0d", i), {31'd0, pix_in_ready}, 1);
        break;
      end
      tick();
      start = 1'b0;
      if (i == NPIX - 1) chk("ready_after_last_pixel", {31'd0, pix_in_ready}, 0);
      if (toggle) begin
        pix_in_valid = 1'b0;
        tick();
      end
    end
    pix_in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(input int fb);
    int g = 0;
    while (nfd == fb && g < 400) begin
      tick();
      g++;
    end
    tick();
    tick();
  endtask

  task automatic check_frame(input string tag, input int pb, input int wb, input int fb);
    chk({tag, " push_count"}, np - pb, NPUSH);
    chk({tag, " win_valid_count"}, nwv - wb, NPIX);
    chk({tag, " frame_done_count"}, nfd - fb, 1);
    if (np - pb == NPUSH) begin
      for (int n = 0; n < NPUSH; n++)
        chk($sformatf("%s push%0d", tag, n), {18'd0, push_rec[pb + n]}, {18'd0, exp_push(n)});
      chk({tag, " sel_at_n27"}, {26'd0, push_rec[pb + 27][5:0]}, 6'b1_00_1_00);
      chk({tag, " sel_at_n34"}, {26'd0, push_rec[pb + 34][5:0]}, 6'b1_00_0_11);
      chk({tag, " sel_at_n87"}, {26'd0, push_rec[pb + 87][5:0]}, 6'b0_11_0_00);
      chk({tag, " flush_back_to_back"}, push_cyc[pb + 90] - push_cyc[pb + 64], 26);
      if (nwv - wb == NPIX) begin
        for (int j = 0; j < NPIX; j++)
          chk($sformatf("%s win_valid%0d_cycle", tag, j), wv_cyc[wb + j],
              push_cyc[pb + P + j] + 1);
      end
      if (nfd - fb >= 1)
        chk({tag, " frame_done_cycle"}, fd_cyc[fb], push_cyc[pb + 90] + 1);
    end
  endtask

  initial begin
    int pb, wb, fb;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset pix_in_ready", {31'd0, pix_in_ready}, 0);
    chk("reset ctrl2buf_valid", {31'd0, ctrl2buf_valid}, 0);
    chk("reset data", {24'd0, data_cu2bufcf}, 0);
    chk("reset sels", {26'd0, sel_top_row, sel_btm_row, sel_left_col, sel_right_col}, 0);
    chk("reset win_valid", {31'd0, win_valid}, 0);
    chk("reset frame_done", {31'd0, frame_done}, 0);
    tick();
    tick();
    chk("idle ready", {31'd0, pix_in_ready}, 0);

    // Back-to-back frame
    pb = np; wb = nwv; fb = nfd;
    start_frame();
    stream(1'b0, NPIX, -1);
    wait_done(fb);
    check_frame("t1", pb, wb, fb);

    // Stalled every other cycle
    pb = np; wb = nwv; fb = nfd;
    start_frame();
    stream(1'b1, NPIX, -1);
    wait_done(fb);
    check_frame("t4", pb, wb, fb);
    if (np - pb >= 2) chk("t4 push_spacing", push_cyc[pb + 1] - push_cyc[pb], 2);

    // Reset while push n=40 is offered
    fb = nfd;
    start_frame();
    stream(1'b0, 40, -1);
    reset = 1'b1;
    pix_in_valid = 1'b1;
    pix_in = pix_val(40);
    tick();
    reset = 1'b0;
    pix_in_valid = 1'b0;
    chk("t5 ready_after_reset", {31'd0, pix_in_ready}, 0);
    chk("t5 valid_after_reset", {31'd0, ctrl2buf_valid}, 0);
    chk("t5 data_after_reset", {24'd0, data_cu2bufcf}, 0);
    chk("t5 sels_after_reset", {26'd0, sel_top_row, sel_btm_row, sel_left_col, sel_right_col},
        0);
    chk("t5 win_valid_after_reset", {31'd0, win_valid}, 0);
    for (int i = 0; i < 60; i++) tick();
    chk("t5 no_frame_done", nfd - fb, 0);
    pb = np; wb = nwv; fb = nfd;
    start_frame();
    stream(1'b0, NPIX, -1);
    wait_done(fb);
    check_frame("t5", pb, wb, fb);

    // start pulses in STREAM and FLUSH are ignored
    pb = np; wb = nwv; fb = nfd;
    start_frame();
    stream(1'b0, NPIX, 10);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(fb);
    check_frame("t6", pb, wb, fb);
    for (int i = 0; i < 5; i++) tick();
    chk("t6 idle_after_frame", {31'd0, pix_in_ready}, 0);
    chk("t6 no_extra_push", np - pb, NPUSH);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
